// File: rtl/lfo_mod_delay_pkg.sv
// lfo_mod_delay_pkg: shared FSM encoding, mix modes
// and saturation helper for the modulated delay line.
package lfo_mod_delay_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD,
    ST_RDW,
    ST_MIX,
    ST_OUT
  } state_t;

  localparam logic [1:0] MIX_DRY = 2'b00;
  localparam logic [1:0] MIX_WET = 2'b01;
  localparam logic [1:0] MIX_AVG = 2'b10;
  localparam logic [1:0] MIX_SUM = 2'b11;

  typedef enum logic [1:0] {
    SAT_NONE,
    SAT_POS,
    SAT_NEG
  } sat_t;

  // Overflow of an N+1 bit sum shows as its top two bits disagreeing.
  function automatic sat_t sat_kind(
    input logic sgn,
    input logic msb
  );
    if (sgn == msb) return SAT_NONE;
    return sgn ? SAT_NEG : SAT_POS;
  endfunction

endpackage

// File: rtl/lfo_mod_delay_sdp_ram.sv
// lfo_mod_delay_sdp_ram: simple dual-port RAM,
// one write port, one registered read port.
module lfo_mod_delay_sdp_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/lfo_mod_delay.sv
// lfo_mod_delay: LFO-modulated circular delay line
// with dry/wet mixing (vibrato, chorus, flanger).
module lfo_mod_delay
  import lfo_mod_delay_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 10,
  parameter int MOD_W       = 6,
  parameter int BASE_DELAY  = 64,
  parameter int DEPTH_SHIFT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_sample,
  input  logic              lfo_valid,
  input  logic [MOD_W-1:0]  lfo_val,
  input  logic [1:0]        mix_mode,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_sample,
  output logic              busy,
  output logic              overrun
);

  localparam logic [31:0] MAX_D = 32'((1 << ADDR_W) - 1);

  state_t state;

  logic signed [DATA_W-1:0] dry_reg;
  logic signed [DATA_W-1:0] wet_reg;
  logic [1:0]               mix_reg;
  logic [MOD_W-1:0]         mod_reg;
  logic [ADDR_W-1:0]        wr_ptr;
  logic [ADDR_W-1:0]        fill_cnt;
  logic [ADDR_W-1:0]        rd_addr;
  logic [ADDR_W-1:0]        dly_reg;
  logic [DATA_W-1:0]        ram_q;

  logic [31:0]              dly_full;
  logic [ADDR_W-1:0]        dly;
  logic signed [DATA_W:0]   sum;
  logic [DATA_W-1:0]        mix_val;
  logic                     ram_we;
  logic                     ram_re;

  always_comb begin
    dly_full = 32'(BASE_DELAY) + (32'(mod_reg) << DEPTH_SHIFT);
    dly      = (dly_full > MAX_D) ? '1 : dly_full[ADDR_W-1:0];
  end

  always_comb begin
    sum = {dry_reg[DATA_W-1], dry_reg}
        + {wet_reg[DATA_W-1], wet_reg};
    mix_val = dry_reg;
    unique case (mix_reg)
      MIX_DRY: mix_val = dry_reg;
      MIX_WET: mix_val = wet_reg;
      MIX_AVG: mix_val = sum[DATA_W:1];
      MIX_SUM: begin
        case (sat_kind(sum[DATA_W], sum[DATA_W-1]))
          SAT_POS: mix_val = {1'b0, {(DATA_W-1){1'b1}}};
          SAT_NEG: mix_val = {1'b1, {(DATA_W-1){1'b0}}};
          default: mix_val = sum[DATA_W-1:0];
        endcase
      end
    endcase
  end

  always_comb begin
    ram_we = (state == ST_WR);
    ram_re = (state == ST_RD);
  end

  lfo_mod_delay_sdp_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_ptr),
    .wdata (dry_reg),
    .re    (ram_re),
    .raddr (rd_addr),
    .rdata (ram_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mod_reg <= '0;
    end else if (lfo_valid) begin
      mod_reg <= lfo_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      dry_reg    <= '0;
      wet_reg    <= '0;
      mix_reg    <= MIX_DRY;
      wr_ptr     <= '0;
      fill_cnt   <= '0;
      rd_addr    <= '0;
      dly_reg    <= '0;
      out_valid  <= 1'b0;
      out_sample <= '0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (in_valid && busy) overrun <= 1'b1;
      unique case (state)
        ST_IDLE: begin
          if (in_valid) begin
            dry_reg <= in_sample;
            mix_reg <= mix_mode;
            busy    <= 1'b1;
            state   <= ST_WR;
          end
        end
        ST_WR: begin
          rd_addr <= wr_ptr - dly;
          dly_reg <= dly;
          state   <= ST_RD;
        end
        ST_RD: begin
          state <= ST_RDW;
        end
        // Slots not yet written since reset read as silence.
        ST_RDW: begin
          wet_reg <= (fill_cnt < dly_reg) ? '0 : ram_q;
          state   <= ST_MIX;
        end
        ST_MIX: begin
          out_sample <= mix_val;
          out_valid  <= 1'b1;
          state      <= ST_OUT;
        end
        ST_OUT: begin
          wr_ptr <= wr_ptr + 1'b1;
          if (fill_cnt != '1) fill_cnt <= fill_cnt + 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lfo_mod_delay.sv
// tb_lfo_mod_delay: scoreboard bench, default instance
// plus a clamped-delay instance (BASE 1000, shift 2).
module tb_lfo_mod_delay;

  logic clk = 1'b0;
  logic rst_n;

  logic              iv [2];
  logic signed [15:0] in_s [2];
  logic              lvv [2];
  logic [5:0]        lv [2];
  logic [1:0]        mm [2];
  logic              ov [2];
  logic signed [15:0] os [2];
  logic              bz [2];
  logic              orun [2];

  int checks = 0;
  int failures = 0;
  longint cyc = 0;

  typedef struct {
    int     val;
    longint cyc;
  } exp_t;

  exp_t sbq0[$];
  exp_t sbq1[$];

  int hist [2][4096];
  int nh [2];
  int cur_lfo [2];
  int base_d [2] = '{64, 1000};
  int dsh [2] = '{0, 2};

  lfo_mod_delay u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (iv[0]),
    .in_sample  (in_s[0]),
    .lfo_valid  (lvv[0]),
    .lfo_val    (lv[0]),
    .mix_mode   (mm[0]),
    .out_valid  (ov[0]),
    .out_sample (os[0]),
    .busy       (bz[0]),
    .overrun    (orun[0])
  );

  lfo_mod_delay #(
    .BASE_DELAY  (1000),
    .DEPTH_SHIFT (2)
  ) u_clamp (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (iv[1]),
    .in_sample  (in_s[1]),
    .lfo_valid  (lvv[1]),
    .lfo_val    (lv[1]),
    .mix_mode   (mm[1]),
    .out_valid  (ov[1]),
    .out_sample (os[1]),
    .busy       (bz[1]),
    .overrun    (orun[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int rnd16();
    logic signed [15:0] r;
    r = 16'($urandom);
    return int'(r);
  endfunction

  // Reference: delayed copy of the accepted-sample history, then mix.
  function automatic int model(input int i, input int dry, input int m);
    int d, wet, s;
    d = base_d[i] + (cur_lfo[i] << dsh[i]);
    if (d > 1023) d = 1023;
    wet = (nh[i] >= d) ? hist[i][nh[i] - d] : 0;
    s = dry + wet;
    case (m)
      0: return dry;
      1: return wet;
      2: return s >>> 1;
      default: return (s > 32767) ? 32767 : ((s < -32768) ? -32768 : s);
    endcase
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (ov[i]) begin
        exp_t e;
        bit got;
        got = 0;
        if (i == 0 && sbq0.size() > 0) begin
          e = sbq0.pop_front();
          got = 1;
        end else if (i == 1 && sbq1.size() > 0) begin
          e = sbq1.pop_front();
          got = 1;
        end
        if (!got) begin
          check($sformatf("unexpected_out%0d", i), 1, 0);
        end else begin
          check($sformatf("out%0d_val", i), int'(os[i]), e.val);
          check($sformatf("out%0d_cyc", i), int'(cyc), int'(e.cyc));
        end
      end
    end
  end

  task automatic lfo_strobe(input int i, input int val);
    @(posedge clk); #1;
    lvv[i] = 1'b1;
    lv[i] = 6'(val);
    cur_lfo[i] = val;
    @(posedge clk); #1;
    lvv[i] = 1'b0;
  endtask

  task automatic send(
    input int i, input int s, input int m,
    input bit lfo_now, input int lval,
    input bit mid, input int mval,
    input bit extra
  );
    exp_t e;
    @(posedge clk); #1;
    check("idle_busy", int'(bz[i]), 0);
    iv[i] = 1'b1;
    in_s[i] = 16'(s);
    mm[i] = 2'(m);
    if (lfo_now) begin
      lvv[i] = 1'b1;
      lv[i] = 6'(lval);
      cur_lfo[i] = lval;
    end
    e.val = model(i, s, m);
    e.cyc = cyc + 5;
    if (i == 0) sbq0.push_back(e);
    else sbq1.push_back(e);
    hist[i][nh[i]] = s;
    nh[i]++;
    for (int j = 1; j <= 5; j++) begin
      @(posedge clk); #1;
      iv[i] = 1'b0;
      lvv[i] = 1'b0;
      if (j == 1) check("busy", int'(bz[i]), 1);
      if (j == 2 && mid) begin
        lvv[i] = 1'b1;
        lv[i] = 6'(mval);
        cur_lfo[i] = mval;
      end
      if (j == 3 && extra) begin
        iv[i] = 1'b1;
        in_s[i] = 16'($urandom);
      end
    end
    if (extra) check("overrun", int'(orun[i]), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      iv[i] = 0; in_s[i] = 0; lvv[i] = 0;
      lv[i] = 0; mm[i] = 0; nh[i] = 0; cur_lfo[i] = 0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check("rst_out_valid", int'(ov[i]), 0);
      check("rst_out_sample", int'(os[i]), 0);
      check("rst_busy", int'(bz[i]), 0);
      check("rst_overrun", int'(orun[i]), 0);
    end
    rst_n = 1'b1;

    // Ramp in wet mode, with LFO steps around samples 150/151.
    for (int k = 1; k <= 200; k++) begin
      if (k == 150) lfo_strobe(0, 32);
      if (k == 151) lfo_strobe(0, 0);
      send(0, k, 1, 0, 0, 0, 0, 0);
    end

    // Mixer corners: saturation both ways, floor average, dry.
    for (int k = 0; k < 70; k++) send(0, 30000, 3, 0, 0, 0, 0, 0);
    for (int k = 0; k < 70; k++) send(0, -30000, 3, 0, 0, 0, 0, 0);
    for (int k = 0; k < 64; k++) send(0, 3, 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 64; k++) send(0, -4, 2, 0, 0, 0, 0, 0);
    for (int k = 0; k < 10; k++) send(0, rnd16(), 0, 0, 0, 0, 0, 0);

    // Random samples, modes and LFO timing (with, between, mid-flight).
    for (int k = 0; k < 150; k++) begin
      if ($urandom_range(0, 7) == 0) lfo_strobe(0, $urandom_range(0, 63));
      send(0, rnd16(), $urandom_range(0, 3),
           $urandom_range(0, 3) == 0, $urandom_range(0, 63),
           $urandom_range(0, 4) == 0, $urandom_range(0, 63), 0);
    end

    // Overrun: second strobe while busy is dropped.
    send(0, 1234, 1, 0, 0, 0, 0, 1);
    for (int k = 0; k < 3; k++) send(0, rnd16(), 1, 0, 0, 0, 0, 0);

    // Reset while the sample sits in RDW.
    @(posedge clk); #1;
    iv[0] = 1'b1; in_s[0] = 16'sd777; mm[0] = 2'd1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", int'(ov[0]), 0);
    check("mid_rst_out_sample", int'(os[0]), 0);
    check("mid_rst_busy", int'(bz[0]), 0);
    check("mid_rst_overrun", int'(orun[0]), 0);
    nh[0] = 0;
    cur_lfo[0] = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    for (int k = 1; k <= 70; k++) send(0, k + 500, 1, 0, 0, 0, 0, 0);

    // Clamped delay on the second instance.
    send(1, rnd16(), 1, 1, 63, 0, 0, 0);
    for (int k = 0; k < 1040; k++) send(1, rnd16(), 1, 0, 0, 0, 0, 0);

    repeat (10) @(posedge clk);
    check("sb0_empty", sbq0.size(), 0);
    check("sb1_empty", sbq1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
